// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte streams.
// A grant lasts for a whole message or MAX_BURST bytes, whichever comes first.
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          tx_start,
    output logic [DATA_WIDTH-1:0]         tx_data,
    input  logic                          tx_busy,
    output logic                          active
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(MAX_BURST);

    typedef enum logic [1:0] {IDLE, LOAD, START, WAIT} state_t;

    state_t                state, state_next;
    logic [PTR_W-1:0]      ptr, ptr_next;
    logic [PTR_W-1:0]      owner, owner_next;
    logic [PTR_W-1:0]      pick;
    logic                  pick_found;
    logic [NUM_REQ-1:0]    grant_next;
    logic [CNT_W-1:0]      burst_cnt, burst_cnt_next;
    logic                  last_q, last_next;
    logic                  tx_start_next;
    logic [DATA_WIDTH-1:0] tx_data_next;
    logic [DATA_WIDTH-1:0] req_bytes [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign req_bytes[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Circular scan starting just after the previous owner.
    always_comb begin
        logic [PTR_W-1:0] cand;
        pick       = '0;
        pick_found = 1'b0;
        cand       = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = PTR_W'((int'(ptr) + i) % NUM_REQ);
            if (!pick_found && req_valid[cand]) begin
                pick       = cand;
                pick_found = 1'b1;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == LOAD && req_valid[owner]) begin
            req_ready[owner] = 1'b1;
        end
    end

    assign active = (state != IDLE);

    always_comb begin
        state_next     = state;
        ptr_next       = ptr;
        owner_next     = owner;
        grant_next     = grant;
        burst_cnt_next = burst_cnt;
        last_next      = last_q;
        tx_start_next  = tx_start;
        tx_data_next   = tx_data;
        unique case (state)
            IDLE: begin
                if (pick_found) begin
                    owner_next     = pick;
                    grant_next     = NUM_REQ'(1) << pick;
                    burst_cnt_next = '0;
                    state_next     = LOAD;
                end
            end
            LOAD: begin
                if (req_valid[owner]) begin
                    tx_data_next   = req_bytes[owner];
                    last_next      = req_last[owner];
                    burst_cnt_next = burst_cnt + CNT_W'(1);
                    // A frame left over from before a reset keeps tx_start low until it ends.
                    tx_start_next  = !tx_busy;
                    state_next     = START;
                end else begin
                    grant_next = '0;
                    ptr_next   = owner;
                    state_next = IDLE;
                end
            end
            START: begin
                if (tx_start) begin
                    if (tx_busy) begin
                        tx_start_next = 1'b0;
                        state_next    = WAIT;
                    end
                end else if (!tx_busy) begin
                    tx_start_next = 1'b1;
                end
            end
            WAIT: begin
                if (!tx_busy) begin
                    if (last_q || burst_cnt == BURST_LIMIT) begin
                        grant_next = '0;
                        ptr_next   = owner;
                        state_next = IDLE;
                    end else begin
                        state_next = LOAD;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= PTR_W'(NUM_REQ - 1);
            owner     <= '0;
            grant     <= '0;
            burst_cnt <= '0;
            last_q    <= 1'b0;
            tx_start  <= 1'b0;
            tx_data   <= '0;
        end else begin
            state     <= state_next;
            ptr       <= ptr_next;
            owner     <= owner_next;
            grant     <= grant_next;
            burst_cnt <= burst_cnt_next;
            last_q    <= last_next;
            tx_start  <= tx_start_next;
            tx_data   <= tx_data_next;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: byte streams are scored against a message-level
// round-robin model, with a behavioural transmitter answering tx_start.
module tb_uart_tx_arbiter;
    localparam int NR = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic             clk;
    logic             reset;
    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_last;
    logic [NR-1:0]    req_ready;
    logic [NR-1:0]    grant;
    logic             tx_start;
    logic [DW-1:0]    tx_data;
    logic             tx_busy;
    logic             active;

    uart_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .grant(grant),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .active(active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef logic [8:0] byteq_t [$];
    byteq_t     drv_q [NR];
    byteq_t     mdl_q [NR];
    logic [9:0] exp_q [$];

    int         errors = 0;
    int         checks = 0;
    int         ptr_model = NR - 1;
    int         hs_count = 0;
    int         ready_count = 0;
    int         byte_count = 0;
    int         cur_delay = 0;
    int         frame_len = 0;
    bit         slow_mode = 1'b0;
    bit         long_frame = 1'b0;
    logic [NR-1:0] acc;
    logic       prev_start = 1'b0;
    logic       prev_busy = 1'b0;
    logic [DW-1:0] prev_data = '0;
    int         hold = 0;
    logic [9:0] exp_item;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name, input string what);
        checks++;
        errors++;
        $display("[TB] FAIL %s: %s", name, what);
    endtask

    function automatic bit drvPending();
        for (int i = 0; i < NR; i++) if (drv_q[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit modelPending();
        for (int i = 0; i < NR; i++) if (mdl_q[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic applyStimulus(input int r, input logic [7:0] d, input bit last);
        drv_q[r].push_back({last, d});
        mdl_q[r].push_back({last, d});
        byte_count++;
    endtask

    // Message-level reference: rotate over non-empty requesters, each grant
    // ending on a last byte, on the burst limit, or when the stream runs dry.
    task automatic runModel();
        int owner;
        int cnt;
        bit done;
        logic [8:0] b;
        while (modelPending()) begin
            owner = -1;
            for (int k = 1; k <= NR; k++) begin
                if (owner < 0 && mdl_q[(ptr_model + k) % NR].size() > 0) owner = (ptr_model + k) % NR;
            end
            cnt  = 0;
            done = 1'b0;
            while (!done) begin
                b = mdl_q[owner].pop_front();
                exp_q.push_back({owner[1:0], b[7:0]});
                cnt++;
                done = b[8] || cnt == MB || mdl_q[owner].size() == 0;
            end
            ptr_model = owner;
        end
    endtask

    task automatic flushStimulus();
        for (int i = 0; i < NR; i++) begin
            byte_count -= drv_q[i].size();
            drv_q[i].delete();
            mdl_q[i].delete();
        end
        exp_q.delete();
        ptr_model = NR - 1;
    endtask

    task automatic waitIdle(input string name);
        int n;
        bit busy_now;
        n = 0;
        do begin
            @(posedge clk); #2;
            n++;
            busy_now = active || tx_busy || exp_q.size() != 0 || drvPending();
        end while (busy_now && n < 5000);
        if (busy_now) failNow(name, $sformatf("still busy after %0d cycles, %0d bytes outstanding", n, exp_q.size()));
    endtask

    task automatic waitHandshakes(input int target, input string name);
        int n;
        n = 0;
        while (hs_count < target && n < 2000) begin @(negedge clk); #1; n++; end
        if (hs_count < target) failNow(name, $sformatf("got %0d handshakes, expected %0d", hs_count, target));
    endtask

    task automatic waitBusyLow(input string name);
        int n;
        n = 0;
        while (tx_busy && n < 200) begin @(negedge clk); #1; n++; end
        if (tx_busy) failNow(name, "tx_busy never fell");
    endtask

    // Requesters present the head of their queue and pop it once accepted.
    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            acc = reset ? '0 : (req_ready & req_valid);
            @(posedge clk); #1;
            for (int i = 0; i < NR; i++) begin
                if (acc[i] && drv_q[i].size() > 0) begin
                    void'(drv_q[i].pop_front());
                    ready_count++;
                end
                if (drv_q[i].size() > 0) begin
                    req_valid[i]        = 1'b1;
                    req_data[i*DW +: DW] = drv_q[i][0][7:0];
                    req_last[i]         = drv_q[i][0][8];
                end else begin
                    req_valid[i]        = 1'b0;
                    req_data[i*DW +: DW] = '0;
                    req_last[i]         = 1'b0;
                end
            end
        end
    end

    // Transmitter: answers tx_start after a delay, then shifts a frame.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (tx_start && !tx_busy) begin
                cur_delay = slow_mode ? 5 : int'($urandom_range(0, 3));
                frame_len = long_frame ? 8 : int'($urandom_range(1, 4));
                repeat (cur_delay) begin @(posedge clk); #1; end
                tx_busy = 1'b1;
                repeat (frame_len) @(posedge clk);
                #1 tx_busy = 1'b0;
            end
        end
    end

    // Monitor: scores each start/busy handshake and the handshake rules.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_start = 1'b0;
                prev_busy  = tx_busy;
                hold       = 0;
            end else begin
                if (req_ready != '0) begin
                    checkOutput("req_ready_onehot", 32'($onehot(req_ready)), 32'd1);
                    checkOutput("req_ready_outside_grant", 32'(req_ready & ~grant), 32'd0);
                end
                if (tx_start) begin
                    hold++;
                    if (!prev_start) checkOutput("start_while_busy", 32'(prev_busy), 32'd0);
                    else checkOutput("tx_data_stable", 32'(tx_data), 32'(prev_data));
                    if (tx_busy) begin
                        hs_count++;
                        checkOutput("start_hold_cycles", hold, cur_delay + 1);
                        if (exp_q.size() == 0) begin
                            failNow("unexpected_byte", $sformatf("got 0x%0h with grant 0x%0h, expected nothing", tx_data, grant));
                        end else begin
                            exp_item = exp_q.pop_front();
                            checkOutput("handshake_grant", 32'(grant), 32'(1) << exp_item[9:8]);
                            checkOutput("handshake_data", 32'(tx_data), 32'(exp_item[7:0]));
                        end
                        hold = 0;
                    end
                end else begin
                    hold = 0;
                end
                prev_start = tx_start;
                prev_busy  = tx_busy;
                prev_data  = tx_data;
            end
        end
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int n;
        int nmsg;
        int len;
        bit endlast;

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_grant", 32'(grant), 32'd0);
        checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
        checkOutput("reset_tx_start", 32'(tx_start), 32'd0);
        checkOutput("reset_tx_data", 32'(tx_data), 32'd0);
        checkOutput("reset_active", 32'(active), 32'd0);

        $display("[TB] single message from requester 2");
        applyStimulus(2, 8'hA1, 1'b0);
        applyStimulus(2, 8'hB2, 1'b0);
        applyStimulus(2, 8'hC3, 1'b1);
        runModel();
        waitIdle("single_msg_timeout");
        @(negedge clk);
        checkOutput("single_msg_grant_after", 32'(grant), 32'd0);
        checkOutput("single_msg_active_after", 32'(active), 32'd0);

        $display("[TB] round-robin between requesters 0 and 1");
        @(posedge clk); #2 reset = 1'b1;
        flushStimulus();
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 8'h10 + 8'(k), 1'b1);
            applyStimulus(1, 8'h20 + 8'(k), 1'b1);
        end
        runModel();
        waitIdle("round_robin_timeout");

        $display("[TB] burst limit on requester 3");
        for (int k = 0; k < 10; k++) applyStimulus(3, 8'h30 + 8'(k), 1'b0);
        applyStimulus(1, 8'h41, 1'b0);
        applyStimulus(1, 8'h42, 1'b1);
        runModel();
        waitIdle("burst_timeout");

        $display("[TB] owner drops valid mid-message");
        base = hs_count;
        applyStimulus(0, 8'h51, 1'b0);
        applyStimulus(0, 8'h52, 1'b0);
        runModel();
        waitHandshakes(base + 2, "drop_handshakes");
        waitBusyLow("drop_busy_low");
        @(negedge clk);
        checkOutput("drop_load_req_ready", 32'(req_ready), 32'd0);
        checkOutput("drop_load_grant", 32'(grant), 32'b0001);
        checkOutput("drop_load_active", 32'(active), 32'd1);
        @(negedge clk);
        checkOutput("drop_release_grant", 32'(grant), 32'd0);
        checkOutput("drop_release_active", 32'(active), 32'd0);
        waitIdle("drop_timeout");
        applyStimulus(0, 8'h61, 1'b1);
        applyStimulus(1, 8'h62, 1'b1);
        runModel();
        waitIdle("drop_next_timeout");

        $display("[TB] slow transmitter");
        slow_mode = 1'b1;
        applyStimulus(2, 8'h71, 1'b0);
        applyStimulus(2, 8'h72, 1'b0);
        applyStimulus(2, 8'h73, 1'b1);
        runModel();
        waitIdle("slow_timeout");
        slow_mode = 1'b0;

        $display("[TB] randomized message batches");
        for (int b = 0; b < 6; b++) begin
            for (int r = 0; r < NR; r++) begin
                if ($urandom_range(0, 1) == 1) begin
                    nmsg = int'($urandom_range(1, 2));
                    for (int m = 0; m < nmsg; m++) begin
                        len     = int'($urandom_range(1, 6));
                        endlast = ($urandom_range(0, 3) != 0);
                        for (int k = 0; k < len; k++) applyStimulus(r, 8'($urandom), endlast && k == len - 1);
                    end
                end
            end
            runModel();
            waitIdle("random_batch_timeout");
        end

        $display("[TB] reset during a frame");
        long_frame = 1'b1;
        base = hs_count;
        applyStimulus(1, 8'h5A, 1'b0);
        applyStimulus(1, 8'hA5, 1'b0);
        applyStimulus(1, 8'h3C, 1'b1);
        runModel();
        waitHandshakes(base + 1, "midframe_handshake");
        @(posedge clk); #2;
        reset = 1'b1;
        flushStimulus();
        @(posedge clk);
        @(negedge clk);
        checkOutput("midframe_reset_grant", 32'(grant), 32'd0);
        checkOutput("midframe_reset_req_ready", 32'(req_ready), 32'd0);
        checkOutput("midframe_reset_tx_start", 32'(tx_start), 32'd0);
        checkOutput("midframe_reset_tx_data", 32'(tx_data), 32'd0);
        checkOutput("midframe_reset_active", 32'(active), 32'd0);
        @(posedge clk); #2;
        reset      = 1'b0;
        long_frame = 1'b0;
        applyStimulus(2, 8'h22, 1'b1);
        applyStimulus(0, 8'h11, 1'b1);
        runModel();
        n = 0;
        do begin @(negedge clk); n++; end while (grant == '0 && n < 50);
        checkOutput("post_reset_first_grant", 32'(grant), 32'b0001);
        checkOutput("post_reset_start_low", 32'(tx_start), 32'd0);
        waitIdle("post_reset_timeout");

        checkOutput("accepts_vs_bytes", ready_count, byte_count);
        checkOutput("leftover_expected", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
